// File: rtl/systolic_array_ctrl.sv
// Sequencer for an N_PE-deep systolic array: cfg load of weights/biases, sample streaming
// with a diagonal accumulate-enable wavefront, flush, and a valid/ready drain of the accumulators.
module systolic_array_ctrl #(
  parameter int N_PE  = 8,
  parameter int DW    = 4,
  parameter int AW    = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             reload_w,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  input  logic [DW-1:0]    cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DW-1:0]    s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [AW-1:0]    res_data,
  output logic [2:0]       res_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [DW-1:0]    arr_data_in,
  output logic [DW-1:0]    arr_weight_in,
  output logic [DW-1:0]    arr_bias_in,
  output logic [N_PE-1:0]  pe_weight_en,
  output logic [N_PE-1:0]  pe_bias_en,
  output logic [N_PE-1:0]  pe_acc_en,
  output logic [2:0]       drain_sel,
  input  logic [AW-1:0]    acc_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_B,
    S_COMPUTE,
    S_FLUSH,
    S_DRAIN
  } state_e;

  localparam logic [2:0] LAST_PE    = 3'(N_PE - 1);
  localparam logic [2:0] LAST_FLUSH = 3'(N_PE - 2);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  smp_q, smp_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic [N_PE-1:1]   en_sr_q, en_sr_d;
  logic              en_sr0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      smp_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      en_sr_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      smp_q   <= smp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      en_sr_q <= en_sr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    smp_d        = smp_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    cfg_ready    = 1'b0;
    s_ready      = 1'b0;
    res_valid    = 1'b0;
    en_sr0       = 1'b0;
    arr_data_in  = '0;
    pe_weight_en = '0;
    pe_bias_en   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          smp_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = reload_w ? S_LOAD_W : S_LOAD_B;
        end
      end

      S_LOAD_W: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          pe_weight_en = N_PE'(1) << cnt_q;
          if (cnt_q == LAST_PE) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_LOAD_B: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          pe_bias_en = N_PE'(1) << cnt_q;
          if (cnt_q == LAST_PE) begin
            cnt_d   = '0;
            smp_d   = '0;
            state_d = (len_q == '0) ? S_DRAIN : S_COMPUTE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      S_COMPUTE: begin
        s_ready = (smp_q != len_q);
        en_sr0  = s_valid & s_ready;
        if (en_sr0) begin
          arr_data_in = s_data;
          smp_d       = smp_q + LEN_W'(1);
          if ((smp_q + LEN_W'(1)) == len_q) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end
        end
      end

      // N_PE-1 idle cycles let the last sample's enable reach the final PE.
      S_FLUSH: begin
        if (cnt_q == LAST_FLUSH) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      S_DRAIN: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (idx_q == LAST_PE) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Bit i of the shift register holds the sample-accept flag from i cycles ago.
  always_comb begin
    en_sr_d = (state_q == S_IDLE) ? '0 : {en_sr_q[N_PE-2:1], en_sr0};
    if ((state_q == S_COMPUTE) || (state_q == S_FLUSH)) begin
      pe_acc_en = {en_sr_q, en_sr0};
    end else begin
      pe_acc_en = '0;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign arr_weight_in = cfg_data;
  assign arr_bias_in   = cfg_data;
  assign drain_sel     = idx_q;
  assign res_idx       = idx_q;
  assign res_data      = acc_in;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: a behavioural array model feeds acc_in, jobs come from a
// directed table plus randomized jobs, results are predicted as bias + weight * sum(samples).
module tb_systolic_array_ctrl;
  localparam int N_PE  = 8;
  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, reload_w;
  logic [LEN_W-1:0] len;
  logic             busy, done;
  logic [DW-1:0]    cfg_data;
  logic             cfg_valid, cfg_ready;
  logic [DW-1:0]    s_data;
  logic             s_valid, s_ready;
  logic [AW-1:0]    res_data;
  logic [2:0]       res_idx;
  logic             res_valid, res_ready;
  logic [DW-1:0]    arr_data_in, arr_weight_in, arr_bias_in;
  logic [N_PE-1:0]  pe_weight_en, pe_bias_en, pe_acc_en;
  logic [2:0]       drain_sel;
  logic [AW-1:0]    acc_in;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.N_PE(N_PE), .DW(DW), .AW(AW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .reload_w(reload_w), .len(len),
    .busy(busy), .done(done),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .res_data(res_data), .res_idx(res_idx), .res_valid(res_valid), .res_ready(res_ready),
    .arr_data_in(arr_data_in), .arr_weight_in(arr_weight_in), .arr_bias_in(arr_bias_in),
    .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en), .pe_acc_en(pe_acc_en),
    .drain_sel(drain_sel), .acc_in(acc_in)
  );

  // Behavioural array: PE i sees the data stream delayed i cycles.
  logic [DW-1:0] mw   [N_PE] = '{default: '0};
  logic [AW-1:0] macc [N_PE] = '{default: '0};
  logic [DW-1:0] dp   [N_PE] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 1; i < N_PE; i++) dp[i] <= (i == 1) ? arr_data_in : dp[i-1];
    for (int i = 0; i < N_PE; i++) begin
      if (pe_weight_en[i]) mw[i] <= arr_weight_in;
      if (pe_bias_en[i]) macc[i] <= AW'(arr_bias_in);
      else if (pe_acc_en[i])
        macc[i] <= macc[i] + AW'(mw[i]) * AW'((i == 0) ? arr_data_in : dp[i]);
    end
  end

  assign acc_in = macc[drain_sel];

  typedef struct {
    bit          rl;
    int          ln;
    bit          rnd;
    logic [31:0] vmask;
    int          stall_idx;
    int          stall_n;
    bit          start_busy;
    bit          t1_vals;
    int          rst_at;
    int          exp_wcyc;
    int          exp_acc7;
  } job_t;

  int          checks = 0;
  int          errors = 0;
  int          wcnt, a7cnt;
  bit          acc_at [0:2047];
  logic [DW-1:0] wv [N_PE];
  logic [DW-1:0] bv [N_PE];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic observe();
    if (pe_weight_en != '0) wcnt++;
    if (pe_acc_en[N_PE-1]) a7cnt++;
  endtask

  function automatic logic [7:0] exp_acc(input int t);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < N_PE; i++) if (t >= i) e[i] = acc_at[t-i];
    return e;
  endfunction

  task automatic load_phase(input bit is_w, input bit rnd);
    int k, n;
    bit v;
    k = 0;
    n = 0;
    while (k < N_PE && n < 200) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid = v;
      cfg_data  = is_w ? wv[k] : bv[k];
      #1;
      chk("cfg_ready", cfg_ready, 1);
      chk("s_ready_load", s_ready, 0);
      chk("weight_en", pe_weight_en, (is_w && v) ? (32'd1 << k) : 32'd0);
      chk("bias_en", pe_bias_en, (!is_w && v) ? (32'd1 << k) : 32'd0);
      chk("acc_en_load", pe_acc_en, 0);
      chk("cfg_pass", is_w ? arr_weight_in : arr_bias_in, cfg_data);
      observe();
      if (v) k++;
      n++;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    if (k < N_PE) chk("load_timeout", k, N_PE);
  endtask

  task automatic run_job(input job_t j);
    int k, n, t, idx, st, sum;
    logic [DW-1:0] d;
    logic [AW-1:0] er;
    bit v, r;
    wcnt = 0;
    a7cnt = 0;
    sum = 0;
    for (int i = 0; i < 2048; i++) acc_at[i] = 1'b0;
    @(negedge clk);
    start = 1'b1;
    reload_w = j.rl;
    len = LEN_W'(j.ln);
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = j.start_busy;
    reload_w = ~j.rl;
    len = LEN_W'($urandom);
    if (j.rl) begin
      for (int i = 0; i < N_PE; i++) wv[i] = j.t1_vals ? DW'(i + 1) : DW'($urandom);
      load_phase(1'b1, j.rnd);
    end
    for (int i = 0; i < N_PE; i++) bv[i] = j.t1_vals ? '0 : DW'($urandom);
    load_phase(1'b0, j.rnd);

    if (j.ln > 0) begin
      t = 0;
      k = 0;
      while (k < j.ln && t < 2000) begin
        if (j.rst_at >= 0 && t == j.rst_at) break;
        v = j.rnd ? ($urandom_range(0, 2) != 0) : j.vmask[t % 32];
        d = j.t1_vals ? DW'(k + 2) : DW'($urandom);
        s_valid = v;
        s_data = d;
        acc_at[t] = v;
        #1;
        chk("s_ready_comp", s_ready, 1);
        chk("data_in_comp", arr_data_in, v ? d : '0);
        chk("acc_en_comp", pe_acc_en, exp_acc(t));
        chk("busy_comp", busy, 1);
        observe();
        if (v) begin
          sum += int'(d);
          k++;
        end
        t++;
        @(negedge clk);
      end
      s_valid = 1'b0;
      if (j.rst_at >= 0) begin
        chk("wcyc_abort", wcnt, j.exp_wcyc);
        chk("acc7_abort", a7cnt, j.exp_acc7);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_enables", {pe_weight_en, pe_bias_en, pe_acc_en}, 0);
        chk("rst_drain_sel", drain_sel, 0);
        @(negedge clk);
        #1;
        chk("rst_no_done", done, 0);
        chk("rst_idle", busy, 0);
        return;
      end
      if (k < j.ln) chk("compute_timeout", k, j.ln);
      for (int f = 0; f < N_PE - 1; f++) begin
        s_valid = 1'b1;
        s_data = DW'($urandom_range(1, 15));
        #1;
        chk("s_ready_flush", s_ready, 0);
        chk("data_in_flush", arr_data_in, 0);
        chk("flush_len", res_valid, 0);
        chk("acc_en_flush", pe_acc_en, exp_acc(t));
        observe();
        t++;
        @(negedge clk);
      end
      s_valid = 1'b0;
    end

    idx = 0;
    n = 0;
    st = 0;
    while (idx < N_PE && n < 200) begin
      start = 1'b0;
      if (j.rnd) r = $urandom_range(0, 1);
      else if (idx == j.stall_idx && st < j.stall_n) begin
        r = 1'b0;
        st++;
      end else r = 1'b1;
      res_ready = r;
      er = AW'(int'(bv[idx]) + int'(wv[idx]) * sum);
      #1;
      chk("res_valid", res_valid, 1);
      chk("res_idx", res_idx, idx);
      chk("drain_sel", drain_sel, idx);
      chk("res_data", res_data, er);
      chk("acc_en_drain", pe_acc_en, 0);
      chk("done_early", done, 0);
      observe();
      if (r) idx++;
      n++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    if (idx < N_PE) chk("drain_timeout", idx, N_PE);
    #1;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    chk("wcyc", wcnt, j.exp_wcyc);
    chk("acc7_count", a7cnt, j.exp_acc7);
    @(negedge clk);
    #1;
    chk("done_once", done, 0);
    chk("stay_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    job_t jobs [6];
    job_t rj;
    jobs[0] = '{1'b1, 3, 1'b0, 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b1, -1, 8, 3};
    jobs[1] = '{1'b0, 4, 1'b0, 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b0, -1, 0, 4};
    jobs[2] = '{1'b0, 2, 1'b0, 32'h0000_0005, -1, 0, 1'b0, 1'b0, -1, 0, 2};
    jobs[3] = '{1'b1, 5, 1'b0, 32'hFFFF_FFFF, 2, 3, 1'b0, 1'b0, -1, 8, 5};
    jobs[4] = '{1'b1, 6, 1'b0, 32'hFFFF_FFFF, -1, 0, 1'b0, 1'b0, 2, 8, 0};
    jobs[5] = '{1'b0, 0, 1'b0, 32'hFFFF_FFFF, -1, 0, 1'b1, 1'b0, -1, 0, 0};

    rst = 1'b1;
    start = 1'b1;
    reload_w = 1'b1;
    len = 8'd5;
    cfg_data = '0;
    cfg_valid = 1'b1;
    s_data = '0;
    s_valid = 1'b1;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_ready", cfg_ready, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_enables", {pe_weight_en, pe_bias_en, pe_acc_en}, 0);
    chk("reset_drain_sel", drain_sel, 0);
    start = 1'b0;
    cfg_valid = 1'b0;
    s_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    for (int i = 0; i < 14; i++) begin
      rj.rl = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rj.ln = (i == 7) ? 255 : int'($urandom_range(0, 12));
      rj.rnd = 1'b1;
      rj.vmask = 32'hFFFF_FFFF;
      rj.stall_idx = -1;
      rj.stall_n = 0;
      rj.start_busy = 1'($urandom_range(0, 1));
      rj.t1_vals = 1'b0;
      rj.rst_at = -1;
      rj.exp_wcyc = rj.rl ? N_PE : 0;
      rj.exp_acc7 = rj.ln;
      run_job(rj);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
